// File: rtl/dac_button_ctrl_if.sv
// Valid/ready write channel between the button front end and the SPI DAC driver.
// The master drives the transaction fields and the slave drives ready.
interface dac_button_ctrl_if #(
  parameter int DATA_W = 12
);
  logic              dac_valid;
  logic              dac_ready;
  logic [DATA_W-1:0] dac_data;
  logic [3:0]        dac_addr;
  logic [3:0]        dac_cmd;

  modport master (
    output dac_valid,
    output dac_data,
    output dac_addr,
    output dac_cmd,
    input  dac_ready
  );

  modport slave (
    input  dac_valid,
    input  dac_data,
    input  dac_addr,
    input  dac_cmd,
    output dac_ready
  );
endinterface

// File: rtl/dac_button_ctrl.sv
// Button/switch front end for the DAC: debounces the east/west buttons, steps a
// saturating level and issues one valid/ready write per accepted event.
module dac_button_ctrl #(
  parameter int         DEBOUNCE_CYCLES = 16,
  parameter int         DATA_W          = 12,
  parameter logic [3:0] DAC_WRITE_CMD   = 4'b0011
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_btn_east,
  input  logic                     i_btn_west,
  input  logic [3:0]               i_sw,
  dac_button_ctrl_if.master        bus,
  output logic [DATA_W-1:0]        o_level
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  logic              r_east_s1, r_east_s2;
  logic              r_west_s1, r_west_s2;
  logic [3:0]        r_sw_s1, r_sw_s2;
  logic [1:0]        r_ch_q;

  logic              r_east_deb, r_east_deb_d;
  logic              r_west_deb, r_west_deb_d;
  logic [CNT_W-1:0]  r_east_cnt, r_west_cnt;

  logic [DATA_W-1:0] r_level;
  logic              r_pending;
  state_t            r_state;

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [3:0]        r_addr;
  logic [3:0]        r_cmd;

  logic              w_east_evt, w_west_evt;
  logic              w_east_only, w_west_only;
  logic              w_ch_change;
  logic              w_pend_set;
  logic [DATA_W-1:0] w_step;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W-1:0] w_inc_sat;
  logic [DATA_W-1:0] w_dec_sat;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_east_s1 <= 1'b0;
      r_east_s2 <= 1'b0;
      r_west_s1 <= 1'b0;
      r_west_s2 <= 1'b0;
      r_sw_s1   <= 4'b0;
      r_sw_s2   <= 4'b0;
      r_ch_q    <= 2'b0;
    end else begin
      r_east_s1 <= i_btn_east;
      r_east_s2 <= r_east_s1;
      r_west_s1 <= i_btn_west;
      r_west_s2 <= r_west_s1;
      r_sw_s1   <= i_sw;
      r_sw_s2   <= r_sw_s1;
      r_ch_q    <= r_sw_s2[3:2];
    end
  end

  // Counter only runs while the input disagrees with the accepted level, so any bounce restarts it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_east_deb   <= 1'b0;
      r_east_deb_d <= 1'b0;
      r_east_cnt   <= '0;
      r_west_deb   <= 1'b0;
      r_west_deb_d <= 1'b0;
      r_west_cnt   <= '0;
    end else begin
      r_east_deb_d <= r_east_deb;
      r_west_deb_d <= r_west_deb;

      if (r_east_s2 == r_east_deb) begin
        r_east_cnt <= '0;
      end else if (r_east_cnt == CNT_LAST) begin
        r_east_deb <= r_east_s2;
        r_east_cnt <= '0;
      end else begin
        r_east_cnt <= r_east_cnt + 1'b1;
      end

      if (r_west_s2 == r_west_deb) begin
        r_west_cnt <= '0;
      end else if (r_west_cnt == CNT_LAST) begin
        r_west_deb <= r_west_s2;
        r_west_cnt <= '0;
      end else begin
        r_west_cnt <= r_west_cnt + 1'b1;
      end
    end
  end

  assign w_east_evt  = r_east_deb & ~r_east_deb_d;
  assign w_west_evt  = r_west_deb & ~r_west_deb_d;
  assign w_east_only = w_east_evt & ~w_west_evt;
  assign w_west_only = w_west_evt & ~w_east_evt;
  assign w_ch_change = (r_sw_s2[3:2] != r_ch_q);
  assign w_pend_set  = w_east_only | w_west_only | w_ch_change;

  always_comb begin
    w_step = '0;
    case (r_sw_s2[1:0])
      2'b00:   w_step = DATA_W'(1);
      2'b01:   w_step = DATA_W'(16);
      2'b10:   w_step = DATA_W'(256);
      default: w_step = DATA_W'(1024);
    endcase
  end

  // One extra bit on the sum catches the overflow that selects the saturated value.
  assign w_sum     = {1'b0, r_level} + {1'b0, w_step};
  assign w_inc_sat = w_sum[DATA_W] ? {DATA_W{1'b1}} : w_sum[DATA_W-1:0];
  assign w_dec_sat = (r_level < w_step) ? '0 : (r_level - w_step);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_level <= '0;
    end else if (w_east_only) begin
      r_level <= w_inc_sat;
    end else if (w_west_only) begin
      r_level <= w_dec_sat;
    end
  end

  // Pending collects every event; a new event in the same cycle the FSM consumes it keeps it set.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_pending <= 1'b0;
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_addr    <= 4'b0;
      r_cmd     <= 4'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_pending) begin
            r_valid <= 1'b1;
            r_data  <= r_level;
            r_addr  <= {2'b00, r_sw_s2[3:2]};
            r_cmd   <= DAC_WRITE_CMD;
            r_state <= SEND;
          end
        end
        SEND: begin
          if (r_valid && bus.dac_ready) begin
            r_valid <= 1'b0;
            r_cmd   <= 4'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_pend_set) begin
        r_pending <= 1'b1;
      end else if (r_state == IDLE && r_pending) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign bus.dac_valid = r_valid;
  assign bus.dac_data  = r_data;
  assign bus.dac_addr  = r_addr;
  assign bus.dac_cmd   = r_cmd;
  assign o_level       = r_level;

endmodule
